axis_rr_arbiter: RTL and testbench

Packet-aware round-robin arbiter that shares one 16-bit AXI-Stream channel among `N_SRC` stream masters. It sits between the per-source stream masters and the single stream slave, and routes one source at a time onto the shared channel. A grant is held from the first beat of a packet through its `tlast` beat. Fairness is round-robin, starting from the source after the last one served.

---
 rtl/axis_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 39 +++
 rtl/axis_rr_arbiter.sv | 84 ++++++++
 tb/tb_axis_rr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-aware AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int GRANT_W    = 3;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first asserted request after i_last, wrapping modulo N_SRC.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]   i_req,
  input  logic [GRANT_W-1:0] i_last,
  output logic               o_found,
  output logic [GRANT_W-1:0] o_idx
);

  logic [2*N_SRC-1:0] w_dbl;
  logic [N_SRC-1:0]   w_rot;
  logic [GRANT_W:0]   w_start;
  logic [GRANT_W:0]   w_ofs;
  logic [GRANT_W:0]   w_sum;

  always_comb begin
    w_dbl   = {i_req, i_req};
    w_start = {1'b0, i_last} + (GRANT_W+1)'(1);
    // After the rotate, bit 0 is the source right after i_last.
    w_rot   = N_SRC'(w_dbl >> w_start);
    o_found = 1'b0;
    w_ofs   = '0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_found = 1'b1;
        w_ofs   = (GRANT_W+1)'(j);
      end
    end
    w_sum = w_start + w_ofs;
    if (w_sum >= (GRANT_W+1)'(N_SRC)) begin
      w_sum = w_sum - (GRANT_W+1)'(N_SRC);
    end
    o_idx = w_sum[GRANT_W-1:0];
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing one AXI-Stream channel among N_SRC masters.
// Handshake: a beat moves when tvalid and tready are both high on a rising edge; the grant is held to the tlast beat.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          s_tvalid,
  input  logic [N_SRC*DATA_W-1:0]   s_tdata,
  input  logic [N_SRC-1:0]          s_tlast,
  output logic [N_SRC-1:0]          s_tready,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic                      grant_vld,
  output logic [GRANT_W-1:0]        grant_id
);

  arb_state_t         r_state;
  logic [GRANT_W-1:0] r_grant;
  logic [GRANT_W-1:0] r_last;
  logic               w_found;
  logic [GRANT_W-1:0] w_pick;
  logic               w_end_beat;

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .i_req   (s_tvalid),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_end_beat = m_tvalid && m_tready && m_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GRANT_W'(N_SRC - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          if (w_end_beat) begin
            r_last  <= r_grant;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Only the locked source reaches the outputs; in IDLE everything is held at zero.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (r_state == LOCK) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (r_grant == GRANT_W'(i)) begin
          m_tvalid    = s_tvalid[i];
          m_tdata     = s_tdata[i*DATA_W +: DATA_W];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end
      end
    end
  end

  assign grant_vld = (r_state == LOCK);
  assign grant_id  = r_grant;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: inputs driven and outputs checked in the clock-low phase.
module tb_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    s_tvalid;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic            m_tvalid;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic            m_tready;
  logic            grant_vld;
  logic [2:0]      grant_id;

  int n_chk;
  int n_pass;
  int n_fail;
  int beat;

  axis_rr_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    s_tvalid[i]          = v;
    s_tdata[i*DW +: DW]  = d;
    s_tlast[i]           = l;
  endtask

  task automatic clear_srcs();
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gvld"}, 32'(grant_vld), 32'd0);
    chk({tag, "_mvld"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_rdy"},  32'(s_tready), 32'd0);
  endtask

  task automatic chk_beat(input string tag, input int id, input logic [DW-1:0] d, input logic l);
    chk({tag, "_gvld"}, 32'(grant_vld), 32'd1);
    chk({tag, "_gid"},  32'(grant_id), 32'(id));
    chk({tag, "_mvld"}, 32'(m_tvalid), 32'd1);
    chk({tag, "_data"}, 32'(m_tdata), 32'(d));
    chk({tag, "_last"}, 32'(m_tlast), 32'(l));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    m_tready = 1'b0;
    clear_srcs();

    // Reset values
    cyc(); settle();
    chk("rst_rdy",   32'(s_tready), 32'd0);
    chk("rst_mvld",  32'(m_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_tdata), 32'd0);
    chk("rst_mlast", 32'(m_tlast), 32'd0);
    chk("rst_gvld",  32'(grant_vld), 32'd0);
    chk("rst_gid",   32'(grant_id), 32'd0);
    cyc(); rst_n = 1'b1;

    // Three-beat packet from source 0
    cyc();
    m_tready = 1'b1;
    set_src(0, 1'b1, 16'h04C7, 1'b0);
    settle(); chk_idle("t1_arb");
    cyc(); settle();
    chk_beat("t1_b0", 0, 16'h04C7, 1'b0);
    chk("t1_b0_rdy", 32'(s_tready), 32'h1);
    cyc(); set_src(0, 1'b1, 16'h04C8, 1'b0); settle();
    chk_beat("t1_b1", 0, 16'h04C8, 1'b0);
    cyc(); set_src(0, 1'b1, 16'h04C9, 1'b1); settle();
    chk_beat("t1_b2", 0, 16'h04C9, 1'b1);
    cyc(); clear_srcs(); settle();
    chk_idle("t1_end");

    // Fresh reset so source 0 leads the rotation again
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1;

    // All four sources hold single-beat packets
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 16'(16'h1000 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      settle(); chk_idle($sformatf("t2_gap%0d", k));
      cyc(); settle();
      chk_beat($sformatf("t2_pkt%0d", k), k % N, 16'(16'h1000 + (k % N)), 1'b1);
      chk($sformatf("t2_rdy%0d", k), 32'(s_tready), 32'(1 << (k % N)));
      cyc();
    end
    clear_srcs(); settle();
    chk_idle("t2_end");

    // Source 2, four beats, downstream ready toggling
    cyc();
    set_src(2, 1'b1, 16'h154C, 1'b0);
    m_tready = 1'b0;
    settle(); chk_idle("t3_arb");
    beat = 0;
    for (int c = 0; c < 7; c++) begin
      cyc();
      m_tready = (c % 2 == 0);
      set_src(2, 1'b1, 16'(16'h154C + beat), beat == 3);
      settle();
      chk_beat($sformatf("t3_c%0d", c), 2, 16'(16'h154C + beat), beat == 3);
      chk($sformatf("t3_rdy%0d", c), 32'(s_tready), m_tready ? 32'h4 : 32'h0);
      if (m_tready) beat++;
    end
    cyc(); clear_srcs(); settle();
    chk_idle("t3_end");
    chk("t3_beats", 32'(beat), 32'd4);

    // Source 1 stalls mid-packet while source 3 waits
    m_tready = 1'b1;
    set_src(1, 1'b1, 16'h2000, 1'b0);
    settle(); chk_idle("t4_arb");
    cyc();
    set_src(3, 1'b1, 16'h3000, 1'b1);
    settle();
    chk_beat("t4_b0", 1, 16'h2000, 1'b0);
    for (int s = 0; s < 3; s++) begin
      cyc(); set_src(1, 1'b0, 16'h2001, 1'b1); settle();
      chk($sformatf("t4_stall_gid%0d", s), 32'(grant_id), 32'd1);
      chk($sformatf("t4_stall_mvld%0d", s), 32'(m_tvalid), 32'd0);
      chk($sformatf("t4_stall_rdy%0d", s), 32'(s_tready), 32'h2);
    end
    cyc(); set_src(1, 1'b1, 16'h2001, 1'b1); settle();
    chk_beat("t4_b1", 1, 16'h2001, 1'b1);
    cyc(); set_src(1, 1'b0, 16'h0000, 1'b0); settle();
    chk_idle("t4_gap");
    cyc(); settle();
    chk_beat("t4_s3", 3, 16'h3000, 1'b1);
    cyc(); clear_srcs(); settle();
    chk_idle("t4_end");

    // Reset pulsed during beat 2 of a five-beat packet from source 1
    set_src(2, 1'b1, 16'h4000, 1'b1);
    cyc(); settle();
    chk_beat("t5_pre", 2, 16'h4000, 1'b1);
    cyc();
    clear_srcs();
    set_src(1, 1'b1, 16'h5000, 1'b0);
    settle(); chk_idle("t5_arb");
    cyc(); settle();
    chk_beat("t5_b0", 1, 16'h5000, 1'b0);
    cyc();
    set_src(1, 1'b1, 16'h5001, 1'b0);
    rst_n = 1'b0;
    settle();
    chk_idle("t5_rst");
    chk("t5_rst_data", 32'(m_tdata), 32'd0);
    cyc();
    clear_srcs();
    set_src(0, 1'b1, 16'h7000, 1'b1);
    set_src(3, 1'b1, 16'h6000, 1'b1);
    settle(); chk_idle("t5_rst2");
    cyc(); rst_n = 1'b1; settle();
    chk_idle("t5_rel");
    cyc(); settle();
    chk_beat("t5_s0", 0, 16'h7000, 1'b1);
    cyc(); set_src(0, 1'b0, 16'h0000, 1'b0); settle();
    chk_idle("t5_gap");
    cyc(); settle();
    chk_beat("t5_s3", 3, 16'h6000, 1'b1);
    cyc(); clear_srcs(); settle();
    chk_idle("t5_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
